// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for the 4-master Wishbone round-robin arbiter.
// Master-side signals (m_*) carry the four requesters' buses packed side by side (master n in
// slice [n*W +: W]); slave-side signals (s_*) are the single shared slave bus.
// modport master : the arbiter's view (drives m_ack/err/rty/dat and s_cyc/stb/we/adr/sel/dat).
// modport slave  : the mirror view, used by whatever surrounds the arbiter.
interface wb_rr_arbiter_if #(
  parameter int unsigned ADR_W = 32,
  parameter int unsigned DAT_W = 32,
  parameter int unsigned SEL_W = 4
);
  logic [3:0]         m_cyc_i;
  logic [3:0]         m_stb_i;
  logic [3:0]         m_we_i;
  logic [4*ADR_W-1:0] m_adr_i;
  logic [4*SEL_W-1:0] m_sel_i;
  logic [4*DAT_W-1:0] m_dat_i;
  logic [3:0]         m_ack_o;
  logic [3:0]         m_err_o;
  logic [3:0]         m_rty_o;
  logic [DAT_W-1:0]   m_dat_o;
  logic               s_cyc_o;
  logic               s_stb_o;
  logic               s_we_o;
  logic [ADR_W-1:0]   s_adr_o;
  logic [SEL_W-1:0]   s_sel_o;
  logic [DAT_W-1:0]   s_dat_o;
  logic [DAT_W-1:0]   s_dat_i;
  logic               s_ack_i;
  logic               s_err_i;
  logic               s_rty_i;

  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output m_ack_o, m_err_o, m_rty_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );

  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among 4 masters.
// The grant is held for the whole CYC-framed cycle; responses go to the owner only; a watchdog
// ends a cycle with ERR after TMO stalled strobe cycles.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : master/slave bus bundle (see wb_rr_arbiter_if)
//   gnt_o        : one-hot current owner, zero when idle
//   tmo_o        : one-cycle pulse while a hung cycle is being killed
module wb_rr_arbiter #(
  parameter int unsigned ADR_W = 32,
  parameter int unsigned DAT_W = 32,
  parameter int unsigned SEL_W = 4,
  parameter int unsigned TMO   = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_rr_arbiter_if.master bus,
  output logic [3:0]      gnt_o,
  output logic            tmo_o
);

  typedef enum logic [1:0] {StIdle, StOwn, StKill} state_e;

  localparam logic [15:0] TmoLim = 16'(TMO);

  state_e             state_q, state_d;
  logic [1:0]         own_q, own_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [15:0]        wdog_q, wdog_d;
  logic               we_q;
  logic [ADR_W-1:0]   adr_q;
  logic [SEL_W-1:0]   sel_q;
  logic [DAT_W-1:0]   dat_q;

  // First requester found scanning upward from start, modulo 4. {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Scan backwards so the candidate nearest to start is the one left standing.
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic               o_cyc, o_stb, o_we;
  logic [ADR_W-1:0]   o_adr;
  logic [SEL_W-1:0]   o_sel;
  logic [DAT_W-1:0]   o_dat;
  logic               stalled;
  logic [1:0]         ptr_next;
  logic [2:0]         pick_idle, pick_rel;

  // Owner's request signals.
  always_comb begin
    o_cyc = bus.m_cyc_i[own_q];
    o_stb = bus.m_stb_i[own_q];
    o_we  = bus.m_we_i[own_q];
    o_adr = bus.m_adr_i[own_q*ADR_W +: ADR_W];
    o_sel = bus.m_sel_i[own_q*SEL_W +: SEL_W];
    o_dat = bus.m_dat_i[own_q*DAT_W +: DAT_W];
  end

  assign stalled   = (state_q == StOwn) && o_cyc && o_stb &&
                     !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i);
  assign ptr_next  = own_q + 2'd1;
  assign pick_idle = rr_pick(bus.m_cyc_i, ptr_q);
  assign pick_rel  = rr_pick(bus.m_cyc_i, ptr_next);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    wdog_d  = '0;
    case (state_q)
      StIdle: begin
        if (pick_idle[2]) begin
          state_d = StOwn;
          own_d   = pick_idle[1:0];
        end
      end
      StOwn: begin
        if (!o_cyc) begin
          // Release: hand over on the same edge, zero dead cycles.
          ptr_d   = ptr_next;
          state_d = pick_rel[2] ? StOwn : StIdle;
          if (pick_rel[2]) own_d = pick_rel[1:0];
        end else if (stalled) begin
          wdog_d = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
          if (wdog_d >= TmoLim) state_d = StKill;
        end
      end
      StKill: begin
        // Killed owner sits last in the scan order, so it waits its turn.
        ptr_d   = ptr_next;
        state_d = pick_rel[2] ? StOwn : StIdle;
        if (pick_rel[2]) own_d = pick_rel[1:0];
      end
      default: state_d = StIdle;
    endcase
  end

  // Output steering.
  always_comb begin
    gnt_o       = '0;
    tmo_o       = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = we_q;
    bus.s_adr_o = adr_q;
    bus.s_sel_o = sel_q;
    bus.s_dat_o = dat_q;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    bus.m_dat_o = bus.s_dat_i;
    case (state_q)
      StOwn: begin
        gnt_o[own_q]       = 1'b1;
        bus.s_cyc_o        = o_cyc;
        bus.s_stb_o        = o_cyc & o_stb;
        bus.s_we_o         = o_we;
        bus.s_adr_o        = o_adr;
        bus.s_sel_o        = o_sel;
        bus.s_dat_o        = o_dat;
        bus.m_ack_o[own_q] = bus.s_ack_i;
        bus.m_err_o[own_q] = bus.s_err_i;
        bus.m_rty_o[own_q] = bus.s_rty_i;
      end
      StKill: begin
        // Slave is cut off, so any late ACK/RTY is dropped here.
        gnt_o[own_q]       = 1'b1;
        bus.m_err_o[own_q] = 1'b1;
        tmo_o              = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      own_q   <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
    end
  end

  // Last driven slave-side values, held while no master owns the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q  <= 1'b0;
      adr_q <= '0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (state_q == StOwn) begin
      we_q  <= o_we;
      adr_q <= o_adr;
      sel_q <= o_sel;
      dat_q <= o_dat;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned TMO   = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] gnt_o;
  logic       tmo_o;
  int         errors = 0;
  int         checks = 0;

  wb_rr_arbiter_if #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W)) bus ();

  wb_rr_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .TMO(TMO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus),
    .gnt_o (gnt_o),
    .tmo_o (tmo_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: arbitration described as "who owns the bus, where does the scan start".
  localparam int MIdle = 0, MOwn = 1, MKill = 2;
  int          m_st, m_own, m_ptr, m_cnt;
  logic        last_we;
  logic [31:0] last_adr, last_dat;
  logic [3:0]  last_sel;

  function automatic int first_from(input logic [3:0] req, input int start);
    for (int k = 0; k < 4; k++) if (req[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = MIdle; m_own = 0; m_ptr = 0; m_cnt = 0;
    last_we = 1'b0; last_adr = '0; last_dat = '0; last_sel = '0;
  endtask

  task automatic model_regrant();
    int f;
    f = first_from(bus.m_cyc_i, m_ptr);
    if (f >= 0) begin m_st = MOwn; m_own = f; end
    else m_st = MIdle;
    m_cnt = 0;
  endtask

  task automatic model_edge();
    if (rst_i) begin model_reset(); return; end
    case (m_st)
      MIdle: model_regrant();
      MOwn: begin
        last_we  = bus.m_we_i[m_own];
        last_adr = bus.m_adr_i[m_own*32 +: 32];
        last_dat = bus.m_dat_i[m_own*32 +: 32];
        last_sel = bus.m_sel_i[m_own*4 +: 4];
        if (!bus.m_cyc_i[m_own]) begin
          m_ptr = (m_own + 1) % 4;
          model_regrant();
        end else begin
          if (bus.m_stb_i[m_own] && !(bus.s_ack_i || bus.s_err_i || bus.s_rty_i))
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
          else
            m_cnt = 0;
          if (m_cnt >= int'(TMO)) m_st = MKill;
        end
      end
      default: begin
        m_ptr = (m_own + 1) % 4;
        model_regrant();
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle comparison of every DUT output against the model.
  task automatic settle(input string tag);
    logic [3:0]  e_gnt, e_ack, e_err, e_rty;
    logic        e_cyc, e_stb, e_we, e_tmo;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    #3;
    e_gnt = '0; e_ack = '0; e_err = '0; e_rty = '0; e_tmo = 1'b0;
    e_cyc = 1'b0; e_stb = 1'b0;
    e_we = last_we; e_adr = last_adr; e_dat = last_dat; e_sel = last_sel;
    if (m_st == MOwn) begin
      e_gnt[m_own] = 1'b1;
      e_cyc = bus.m_cyc_i[m_own];
      e_stb = bus.m_cyc_i[m_own] & bus.m_stb_i[m_own];
      e_we  = bus.m_we_i[m_own];
      e_adr = bus.m_adr_i[m_own*32 +: 32];
      e_dat = bus.m_dat_i[m_own*32 +: 32];
      e_sel = bus.m_sel_i[m_own*4 +: 4];
      e_ack[m_own] = bus.s_ack_i;
      e_err[m_own] = bus.s_err_i;
      e_rty[m_own] = bus.s_rty_i;
    end else if (m_st == MKill) begin
      e_gnt[m_own] = 1'b1;
      e_err[m_own] = 1'b1;
      e_tmo = 1'b1;
    end
    chk({tag, ".gnt"}, 64'(gnt_o), 64'(e_gnt));
    chk({tag, ".tmo"}, 64'(tmo_o), 64'(e_tmo));
    chk({tag, ".s_cyc"}, 64'(bus.s_cyc_o), 64'(e_cyc));
    chk({tag, ".s_stb"}, 64'(bus.s_stb_o), 64'(e_stb));
    chk({tag, ".s_we"}, 64'(bus.s_we_o), 64'(e_we));
    chk({tag, ".s_adr"}, 64'(bus.s_adr_o), 64'(e_adr));
    chk({tag, ".s_dat"}, 64'(bus.s_dat_o), 64'(e_dat));
    chk({tag, ".s_sel"}, 64'(bus.s_sel_o), 64'(e_sel));
    chk({tag, ".m_ack"}, 64'(bus.m_ack_o), 64'(e_ack));
    chk({tag, ".m_err"}, 64'(bus.m_err_o), 64'(e_err));
    chk({tag, ".m_rty"}, 64'(bus.m_rty_o), 64'(e_rty));
    chk({tag, ".m_dat"}, 64'(bus.m_dat_o), 64'(bus.s_dat_i));
  endtask

  task automatic edge_();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic step(input string tag);
    settle(tag);
    edge_();
  endtask

  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    bus.m_cyc_i[n] = cyc;
    bus.m_stb_i[n] = stb;
    bus.m_we_i[n]  = we;
    bus.m_adr_i[n*32 +: 32] = adr;
    bus.m_dat_i[n*32 +: 32] = dat;
    bus.m_sel_i[n*4 +: 4]   = 4'hF;
  endtask

  task automatic set_s(input logic ack, input logic err, input logic rty, input logic [31:0] d);
    bus.s_ack_i = ack; bus.s_err_i = err; bus.s_rty_i = rty; bus.s_dat_i = d;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_i = 1'b1;
    for (int n = 0; n < 4; n++) set_m(n, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_s(1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    step("reset");
    step("reset2");
    rst_i = 1'b0;

    // 1: priority after reset, master 1 single write.
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h100, 32'hA5A5A5A5);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h300, 32'h33333333);
    step("t1_req");
    set_s(1'b1, 1'b0, 1'b0, 32'h12345678);
    settle("t1_own");
    chk("t1_gnt", 64'(gnt_o), 64'h2);
    chk("t1_adr", 64'(bus.s_adr_o), 64'h100);
    chk("t1_dat", 64'(bus.s_dat_o), 64'hA5A5A5A5);
    chk("t1_ack", 64'(bus.m_ack_o), 64'h2);
    edge_();
    set_s(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h100, 32'hA5A5A5A5);
    step("t1_rel");
    set_s(1'b1, 1'b0, 1'b0, 32'h0);
    settle("t1_m3");
    chk("t1_gnt3", 64'(gnt_o), 64'h8);
    edge_();
    set_s(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(3, 1'b0, 1'b0, 1'b0, 32'h300, 32'h33333333);
    step("t1_drop");
    step("t1_idle");

    // 2: round-robin fairness from a fresh pointer.
    rst_i = 1'b1;
    #1;
    model_reset();
    step("t2_rst");
    rst_i = 1'b0;
    for (int n = 0; n < 4; n++) set_m(n, 1'b1, 1'b1, 1'b0, 32'h1000 + n, 32'h0);
    step("t2_req");
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 4; n++) if (k < 4) bus.m_cyc_i[n] = 1'b1;
      set_s(1'b1, 1'b0, 1'b0, $urandom());
      settle("t2_rd");
      chk("t2_gnt", 64'(gnt_o), 64'(4'b1 << order[k]));
      chk("t2_ack", 64'(bus.m_ack_o), 64'(4'b1 << order[k]));
      edge_();
      set_s(1'b0, 1'b0, 1'b0, 32'h0);
      if (k == 4) bus.m_cyc_i = 4'b0000;
      else bus.m_cyc_i[order[k]] = 1'b0;
      step("t2_rel");
    end

    // 3: block write with STB gap is not preempted.
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h200, 32'h11111111);
    step("t3_req");
    set_s(1'b1, 1'b0, 1'b0, 32'h0);
    settle("t3_b1");
    chk("t3_gnt_b1", 64'(gnt_o), 64'h4);
    edge_();
    set_s(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(2, 1'b1, 1'b0, 1'b1, 32'h200, 32'h11111111);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h000, 32'h0);
    step("t3_gap");
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h204, 32'h22222222);
    set_s(1'b1, 1'b0, 1'b0, 32'h0);
    settle("t3_b2");
    chk("t3_gnt_b2", 64'(gnt_o), 64'h4);
    edge_();
    set_s(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(2, 1'b0, 1'b0, 1'b1, 32'h204, 32'h22222222);
    settle("t3_drop");
    chk("t3_cyc_rel", 64'(bus.s_cyc_o), 64'h0);
    chk("t3_gnt_rel", 64'(gnt_o), 64'h4);
    edge_();
    settle("t3_hand");
    chk("t3_gnt0", 64'(gnt_o), 64'h1);
    chk("t3_cyc0", 64'(bus.s_cyc_o), 64'h1);
    edge_();

    // 4: watchdog on master 3 with a silent slave; late ACK in KILL is discarded.
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(3, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    step("t4_rel");
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    for (int i = 0; i < int'(TMO); i++) begin
      settle("t4_wait");
      chk("t4_no_tmo", 64'(tmo_o), 64'h0);
      edge_();
    end
    set_s(1'b1, 1'b0, 1'b0, 32'h0);
    settle("t4_kill");
    chk("t4_tmo", 64'(tmo_o), 64'h1);
    chk("t4_err", 64'(bus.m_err_o), 64'h8);
    chk("t4_ack", 64'(bus.m_ack_o), 64'h0);
    chk("t4_cyc", 64'(bus.s_cyc_o), 64'h0);
    edge_();
    set_s(1'b0, 1'b0, 1'b0, 32'h0);
    set_m(3, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
    settle("t4_next");
    chk("t4_gnt1", 64'(gnt_o), 64'h2);
    chk("t4_tmo_off", 64'(tmo_o), 64'h0);
    edge_();

    // 5: response isolation to owner 0.
    set_m(1, 1'b0, 1'b0, 1'b0, 32'h104, 32'h0);
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h040, 32'h0);
    step("t5_rel");
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h108, 32'h0);
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h208, 32'h0);
    set_s(1'b0, 1'b0, 1'b1, 32'h0);
    settle("t5_rty");
    chk("t5_rty", 64'(bus.m_rty_o), 64'h1);
    chk("t5_rty_err", 64'(bus.m_err_o), 64'h0);
    edge_();
    set_s(1'b0, 1'b1, 1'b0, 32'h0);
    settle("t5_err");
    chk("t5_err", 64'(bus.m_err_o), 64'h1);
    chk("t5_err_rty", 64'(bus.m_rty_o), 64'h0);
    edge_();
    set_s(1'b1, 1'b1, 1'b0, 32'h0);
    settle("t5_both");
    chk("t5_both_ack", 64'(bus.m_ack_o), 64'h1);
    chk("t5_both_err", 64'(bus.m_err_o), 64'h1);
    edge_();
    set_s(1'b0, 1'b0, 1'b0, 32'hCAFEF00D);
    settle("t5_quiet");
    chk("t5_cyc_read", 64'(bus.s_cyc_o), 64'h1);
    edge_();

    // 6: asynchronous reset during an owned read.
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("t6_cyc", 64'(bus.s_cyc_o), 64'h0);
    chk("t6_stb", 64'(bus.s_stb_o), 64'h0);
    chk("t6_gnt", 64'(gnt_o), 64'h0);
    step("t6_rst");
    rst_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step("t6_idle");
    settle("t6_first");
    chk("t6_gnt1", 64'(gnt_o), 64'h2);
    edge_();

    // Randomised traffic with responsive and silent slave phases.
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic silent;
      silent = ((cyc / 80) % 3) == 2;
      for (int n = 0; n < 4; n++) begin
        logic c;
        c = bus.m_cyc_i[n];
        c = c ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        bus.m_cyc_i[n] = c;
        bus.m_stb_i[n] = c && ($urandom_range(0, 3) != 0);
        bus.m_we_i[n]  = 1'($urandom_range(0, 1));
        bus.m_adr_i[n*32 +: 32] = $urandom();
        bus.m_dat_i[n*32 +: 32] = $urandom();
        bus.m_sel_i[n*4 +: 4]   = 4'($urandom());
      end
      set_s(!silent && ($urandom_range(0, 2) == 0), !silent && ($urandom_range(0, 15) == 0),
            !silent && ($urandom_range(0, 15) == 0), $urandom());
      step("rnd");
    end
    bus.m_cyc_i = 4'b0000;
    set_s(1'b0, 1'b0, 1'b0, 32'h0);
    step("end1");
    step("end2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Shares one Wishbone classic slave bus among 4 bus masters using round-robin arbitration.
- Sits between the masters (single/block read/write engines) and the shared slave interconnect.
- Holds the grant for the whole CYC-framed cycle, so block transfers are never split.
- Routes ACK/ERR/RTY back to the owner only, and includes a watchdog that terminates hung cycles with ERR.

Parameters:
- ADR_W, 32, address width per master.
- DAT_W, 32, data width.
- SEL_W, 4, byte-select width.
- TMO, 255, watchdog limit in clk_i cycles with STB high and no termination; legal range 2..65535.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- m_cyc_i  in  4  per-master CYC; bit n = master n.
- m_stb_i  in  4  per-master STB.
- m_we_i  in  4  per-master WE.
- m_adr_i  in  4*ADR_W  per-master address; master n in slice [n*ADR_W +: ADR_W].
- m_sel_i  in  4*SEL_W  per-master byte selects.
- m_dat_i  in  4*DAT_W  per-master write data.
- m_ack_o  out  4  per-master ACK.
- m_err_o  out  4  per-master ERR.
- m_rty_o  out  4  per-master RTY.
- m_dat_o  out  DAT_W  read data, broadcast to all masters.
- s_cyc_o  out  1  slave CYC.
- s_stb_o  out  1  slave STB.
- s_we_o  out  1  slave WE.
- s_adr_o  out  ADR_W  slave address.
- s_sel_o  out  SEL_W  slave byte selects.
- s_dat_o  out  DAT_W  slave write data.
- s_dat_i  in  DAT_W  slave read data.
- s_ack_i  in  1  slave ACK.
- s_err_i  in  1  slave ERR.
- s_rty_i  in  1  slave RTY.
- gnt_o  out  4  one-hot current owner; all zero when idle.
- tmo_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values: gnt_o=0, round-robin pointer=0, state IDLE, watchdog count=0, tmo_o=0.
  - s_cyc_o=0, s_stb_o=0, s_we_o=0, s_adr_o=0, s_sel_o=0, s_dat_o=0.
  - m_ack_o=0, m_err_o=0, m_rty_o=0.
- Reset mid-cycle drops the grant immediately; the slave sees CYC/STB fall asynchronously.
- States: IDLE (no owner), OWN (owner registered in gnt_o), KILL (watchdog termination).
- IDLE:
  - At a clock edge where any m_cyc_i bit is high, grant the first requester found scanning from pointer upward, modulo 4.
  - Go to OWN. Arbitration latency is 1 cycle from CYC to s_cyc_o.
- OWN:
  - Slave outputs are a combinational mux of the owner's signals.
  - s_cyc_o = owner CYC; s_stb_o = owner CYC AND owner STB.
  - The owner's m_ack_o/m_err_o/m_rty_o = s_ack_i/s_err_i/s_rty_i. Non-owners see 0.
  - m_dat_o = s_dat_i always.
- Release:
  - Triggered at an edge where the owner's m_cyc_i=0.
  - pointer <= owner+1 (wraps 3->0).
  - In the same edge, grant the next requester scanning from the new pointer. If there is none, go to IDLE.
  - Zero dead cycles between owners. s_cyc_o is low during the owner's release cycle because it is gated by the owner's CYC.
- Non-owner requests never preempt the owner, including during block transfers with STB gaps.
- Idle slave outputs: s_cyc_o=0, s_stb_o=0; address/data/sel/we hold their last value.
- Watchdog counter:
  - Increments each cycle in OWN with s_stb_o=1 and no s_ack_i/s_err_i/s_rty_i.
  - Clears on any termination or when STB is low. Saturates; no wrap.
  - When the count reaches TMO, go to KILL.
- KILL (exactly 1 cycle):
  - s_cyc_o=0, s_stb_o=0.
  - Owner's m_err_o=1; owner's m_ack_o and m_rty_o forced to 0.
  - tmo_o=1.
  - Then behave as release: pointer advances and the next requester is granted; the killed owner is not re-granted until its turn.
- A late slave ACK arriving in KILL is discarded.
- Simultaneous ACK and ERR from the slave: pass both through unchanged; no arbitration on responses.

Test Plan:
1. Priority after reset: m_cyc_i=4'b1010 at the same edge -> gnt_o=4'b0010 one cycle later; master 1 single write adr=0x100, dat=0xA5A5A5A5 reaches the slave; ack returned only on m_ack_o[1].
2. Round-robin fairness: all 4 masters hold CYC continuously, each doing one single read then dropping CYC for 1 cycle -> grant order 0,1,2,3,0; no master granted twice before all others.
3. Block transfer hold: master 2 runs a 2-beat block write with a 1-cycle STB gap while master 0 requests -> gnt_o stays 4'b0100 until master 2 drops CYC, then 4'b0001 on the same edge; s_cyc_o low for exactly that one cycle.
4. Watchdog: TMO=8, master 3 STB high with the slave never acknowledging -> after 8 cycles, m_err_o[3]=1 and tmo_o=1 for 1 cycle; s_cyc_o=0; the next requester is granted.
5. Response isolation: slave asserts s_rty_i and then s_err_i to owner 0 -> m_rty_o/m_err_o toggle only in bit 0; bits 1-3 stay 0.
6. Reset mid-cycle: assert rst_i during an owned read -> s_cyc_o, s_stb_o and gnt_o are 0 before the next clk_i edge; after release, the first grant follows the pointer=0 order.
